// File: rtl/display_sequencer.sv
// rtl/display_sequencer.sv - display view sequencer: invest/balance/win views with timeouts (optional blink: DISPLAY_SEQ_BLINK_EN)
module display_sequencer #(
  parameter int HOLD_TICKS  = 50,
  parameter int WIN_TICKS   = 100,
  parameter int BLINK_TICKS = 10,
  parameter int TIMER_W     = 24
) (
  input  logic        gameClk,
  input  logic        reset_n,
  input  logic        status_btn,
  input  logic        win_event,
  input  logic [10:0] win_amount,
  input  logic [10:0] current_money_invested,
  input  logic [10:0] current_balance,
  output logic [10:0] number_to_display,
  output logic [1:0]  display_sel,
  output logic        display_blank
);

  typedef enum logic [1:0] {
    ST_INVEST  = 2'd0,
    ST_BALANCE = 2'd1,
    ST_WIN     = 2'd2
  } state_t;

  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_TICKS - 1);
  localparam logic [TIMER_W-1:0] WIN_LOAD  = TIMER_W'(WIN_TICKS - 1);

  state_t              state_q, state_d;
  logic                btn_q;
  logic                rise;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [10:0]         win_q, win_d;
  logic [10:0]         num_q, num_d;

  // btn_q resets to 1 so a button held through reset never looks like a press
  assign rise = status_btn & ~btn_q;

  // Next-state, timeout timer and win latch; a win pulse overrides everything
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    win_d   = win_q;
    if (win_event) begin
      state_d = ST_WIN;
      timer_d = WIN_LOAD;
      win_d   = win_amount;
    end else begin
      unique case (state_q)
        ST_INVEST: begin
          if (rise) begin
            state_d = ST_BALANCE;
            timer_d = HOLD_LOAD;
          end
        end
        ST_BALANCE: begin
          // a second press and expiry both return to the invest view
          if (rise || (timer_q == '0)) begin
            state_d = ST_INVEST;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        ST_WIN: begin
          // button presses are ignored while announcing a win
          if (timer_q == '0) begin
            state_d = ST_INVEST;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        default: begin
          state_d = ST_INVEST;
          timer_d = '0;
        end
      endcase
    end
  end

  // Output mux driven from the next state so the value and view change together
  always_comb begin
    num_d = current_money_invested;
    unique case (state_d)
      ST_INVEST:  num_d = current_money_invested;
      ST_BALANCE: num_d = current_balance;
      ST_WIN:     num_d = win_d;
      default:    num_d = current_money_invested;
    endcase
  end

  // Core state and output registers
  always_ff @(posedge gameClk) begin
    if (!reset_n) begin
      state_q <= ST_INVEST;
      btn_q   <= 1'b1;
      timer_q <= '0;
      win_q   <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      btn_q   <= status_btn;
      timer_q <= timer_d;
      win_q   <= win_d;
      num_q   <= num_d;
    end
  end

  assign number_to_display = num_q;
  assign display_sel       = state_q;

`ifdef DISPLAY_SEQ_BLINK_EN
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               blank_q, blank_d;

  // Blink phase: restarts on every win pulse, toggles each half-period, 0 outside WIN
  always_comb begin
    blink_d = '0;
    blank_d = 1'b0;
    if ((state_d == ST_WIN) && !win_event) begin
      if (blink_q == BLINK_LAST) begin
        blink_d = '0;
        blank_d = ~blank_q;
      end else begin
        blink_d = blink_q + BLINK_W'(1);
        blank_d = blank_q;
      end
    end
  end

  // Blink counter and blank output registers
  always_ff @(posedge gameClk) begin
    if (!reset_n) begin
      blink_q <= '0;
      blank_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
      blank_q <= blank_d;
    end
  end

  assign display_blank = blank_q;
`else
  // Without blinking the digits are never blanked (BLINK_TICKS >= 1 keeps this 0)
  assign display_blank = (BLINK_TICKS < 1);
`endif

endmodule

// File: doc/display_sequencer.md
# display_sequencer

Controller that sequences the 11-bit seven-segment display datapath between the invested amount, the player balance and a latched win amount. Replaces the direct button-to-mux selection with a registered state machine that adds button edge detection, auto-return timeouts and a win-announcement mode with optional blinking. Sits between the game logic (`current_money_invested`, `current_balance`, win pulse) and the display decoder.

## Interface
- `HOLD_TICKS`, 50, gameClk cycles the balance view stays up before auto-return (≥1)
- `WIN_TICKS`, 100, gameClk cycles the win view stays up (≥1)
- `BLINK_TICKS`, 10, gameClk cycles per blink half-period in win view (≥1)
- `TIMER_W`, 24, width of the timeout counter; must hold max(HOLD_TICKS, WIN_TICKS)
- `gameClk`  in  1  single clock, all logic on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `status_btn`  in  1  level from the already-debounced status button
- `win_event`  in  1  single-cycle pulse: a spin produced a payout
- `win_amount`  in  11  payout amount, valid when `win_event`=1
- `current_money_invested`  in  11  two's-complement invested amount
- `current_balance`  in  11  two's-complement balance (may be negative)
- `number_to_display`  out  11  registered value for the display decoder
- `display_sel`  out  2  registered view: 0=INVEST, 1=BALANCE, 2=WIN
- `display_blank`  out  1  registered; 1 = decoder blanks the digits

## Operation
- States: INVEST (default), BALANCE, WIN. `display_sel` encodes state.
- Button edge: `btn_q` registers `status_btn`; `rise = status_btn & ~btn_q`.
- INVEST: `win_event` → WIN; else `rise` → BALANCE, timer loads HOLD_TICKS-1.
- BALANCE: `win_event` → WIN; else `rise` → INVEST; else timer==0 → INVEST; else timer decrements.
- WIN: entry latches `win_amount` into `win_q`, timer loads WIN_TICKS-1, blink counter clears, `display_blank`=0. `win_event` in WIN re-latches `win_q` and reloads the timer. `rise` ignored. Timer==0 → INVEST.
- Priority: `win_event` > timer expiry > `rise`, except BALANCE where `rise` and expiry in the same cycle both give INVEST.
- Output mux (from next state): INVEST → `current_money_invested`, BALANCE → `current_balance`, WIN → `win_q` (or `win_amount` in the latching cycle). Values pass unmodified; no sign or width conversion, 11 bits throughout.
- In INVEST/BALANCE the display tracks the source every cycle, not a snapshot.

## Timing
- All outputs registered. Inputs sampled at edge E appear on outputs after E (1-cycle latency). State and outputs update on the same edge.
- Reset (`reset_n`=0 at an edge): state=INVEST, `number_to_display`=0, `display_sel`=0, `display_blank`=0, timer=0, blink counter=0, `win_q`=0, `btn_q`=1. With `btn_q`=1, a button held through reset gives no edge.
- Reset mid-WIN or mid-BALANCE aborts immediately; there is no resume.
- BALANCE entered at edge E with no further events: returns to INVEST at edge E+HOLD_TICKS.
- WIN entered at edge E: returns to INVEST at edge E+WIN_TICKS.
- Holding `status_btn` high gives exactly one transition.

## Configuration
- `DISPLAY_SEQ_BLINK_EN` defined: in WIN, `display_blank` toggles every BLINK_TICKS cycles, starting at 0 on entry. Re-entry by `win_event` restarts the phase at 0. Leaving WIN forces 0.
- Not defined: blink counter is not synthesized and `display_blank` is constant 0.

## Test plan
- Reset with `status_btn`=1 held, invested=20, then release reset → `display_sel`=0, `number_to_display`=20 one cycle later, no transition while the button stays high.
- Button 0→1 with balance=-25 (11'h7E7), HOLD_TICKS=4 → `display_sel`=1, display=11'h7E7 at edge E, back to 0 / invested value at edge E+4.
- In BALANCE, second rise at E+2 → INVEST at E+2, timer disregarded.
- `win_event` with `win_amount`=150 and a same-cycle button rise in INVEST → `display_sel`=2, display=150; button ignored. WIN_TICKS=6 → INVEST at E+6. With `DISPLAY_SEQ_BLINK_EN` and BLINK_TICKS=2, `display_blank` reads 0,0,1,1,0,0.
- Second `win_event` (amount 300) at E+3 in WIN → display=300, exit moves to E+3+WIN_TICKS.
- Assert `reset_n`=0 mid-WIN → next edge all outputs 0, `display_sel`=0.
